// File: rtl/reg_mux_scan_pkg.sv
// Shared definitions for the registered N-channel mux with auto-scan:
// mode encodings and the index-width helpers used to size select/counter fields.
package reg_mux_scan_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Index fields are never narrower than one bit, even for a single entry.
   function automatic int idx_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/reg_mux_scan_scan_counter.sv
// Scan pointer and dwell counter: dwells DWELL enabled cycles per channel and
// pulses wrap for one cycle when the pointer returns from the last channel to 0.
module reg_mux_scan_scan_counter
   import reg_mux_scan_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int DWELL    = 1
)(
   input  logic                           clk,
   input  logic                           clrn,
   input  logic                           en,
   input  logic                           run,
   output logic [idx_width(CHANNELS)-1:0] ptr,
   output logic                           wrap
);

   localparam int SELW = idx_width(CHANNELS);
   localparam int DCW  = idx_width(DWELL);
   localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);
   localparam logic [DCW-1:0]  LAST_DW = DCW'(DWELL - 1);

   logic [DCW-1:0] dcnt;

   // NOTE: registers are written with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ptr  <= '0;
         dcnt <= '0;
         wrap <= 1'b0;
      end else if (!en) begin
         wrap <= 1'b0;
      end else if (!run) begin
         // Leaving scan discards the dwell so the next scan starts fresh at 0.
         ptr  <= '0;
         dcnt <= '0;
         wrap <= 1'b0;
      end else if (dcnt != LAST_DW) begin
         dcnt <= dcnt + DCW'(1);
         wrap <= 1'b0;
      end else begin
         dcnt <= '0;
         if (ptr == LAST_CH) begin
            ptr  <= '0;
            wrap <= 1'b1;
         end else begin
            ptr  <= ptr + SELW'(1);
            wrap <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/reg_mux_scan.sv
// Registered N-channel multiplexer with true/complement outputs, channel tag,
// and an auto-scan mode that steps through the channels at a fixed dwell.
module reg_mux_scan
   import reg_mux_scan_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 2,
   parameter int DWELL    = 1
)(
   input  logic                           clk,
   input  logic                           clrn,
   input  logic                           en,
   input  logic                           mode,
   input  logic [idx_width(CHANNELS)-1:0] sel,
   input  logic [CHANNELS*WIDTH-1:0]      din,
   output logic [WIDTH-1:0]               dout,
   output logic [WIDTH-1:0]               dout_n,
   output logic [idx_width(CHANNELS)-1:0] ch,
   output logic                           valid,
   output logic                           wrap
);

   localparam int SELW = idx_width(CHANNELS);

   logic            run;
   logic [SELW-1:0] ptr;
   logic [SELW-1:0] idx;
   logic [WIDTH-1:0] sample;
   logic            hit;

   assign run = (mode_e'(mode) == MODE_SCAN);

   reg_mux_scan_scan_counter #(
      .CHANNELS (CHANNELS),
      .DWELL    (DWELL)
   ) u_scan (
      .clk  (clk),
      .clrn (clrn),
      .en   (en),
      .run  (run),
      .ptr  (ptr),
      .wrap (wrap)
   );

   // NOTE: every variable gets a default before the loop so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      idx    = run ? ptr : sel;
      sample = '0;
      hit    = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (idx == SELW'(k)) begin
            sample = din[k*WIDTH +: WIDTH];
            hit    = 1'b1;
         end
      end
   end

   // An out-of-range manual select keeps the last good sample and drops valid.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         dout   <= '0;
         dout_n <= '1;
         ch     <= '0;
         valid  <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (en && hit) begin
            dout   <= sample;
            dout_n <= ~sample;
            ch     <= idx;
            valid  <= 1'b1;
         end
      end
   end

endmodule

// File: doc/reg_mux_scan.md
# reg_mux_scan

Parametrised registered N-channel multiplexer, the successor of the 2:1 mux-into-DFF-with-inverted-output cell. It selects one WIDTH-bit channel out of CHANNELS, registers it, and drives true and complemented outputs. A built-in auto-scan mode steps through the channels at a programmable dwell rate. It sits between board-level input banks and downstream logic that needs a stable, clocked, channel-tagged sample.

## Interface
- WIDTH, 1, bits per channel (≥1)
- CHANNELS, 2, number of input channels (≥1)
- DWELL, 1, enabled cycles spent on each channel in scan mode (≥1)
- SELW, derived = max(1, clog2(CHANNELS)), width of select/index; not overridden
- clk  in  1  rising-edge clock
- clrn  in  1  reset, asynchronous, active-low
- en  in  1  clock enable for all state
- mode  in  1  0 = manual select, 1 = auto-scan
- sel  in  SELW  manual channel select
- din  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- dout  out  WIDTH  registered selected channel
- dout_n  out  WIDTH  bitwise complement of dout, registered
- ch  out  SELW  index of the channel currently on dout
- valid  out  1  dout/ch updated by the last edge
- wrap  out  1  one-cycle pulse when scan returns to channel 0

## Operation
- Reset (clrn=0, async): dout=0, dout_n=all ones, ch=0, valid=0, wrap=0, scan pointer ptr=0, dwell counter dcnt=0. Release is synchronous to the next clk edge.
- Selected index idx = (mode ? ptr : sel).
- en=1, idx < CHANNELS: dout<=din[idx], dout_n<=~din[idx], ch<=idx, valid<=1.
- en=1, manual, sel ≥ CHANNELS: dout, dout_n and ch hold; valid<=0.
- en=0: dout, dout_n, ch, ptr and dcnt hold; valid<=0, wrap<=0.
- Manual mode (mode=0): ptr and dcnt are forced to 0 on every edge, so scan always starts at channel 0 with a full dwell. wrap stays 0.
- Scan mode (mode=1), on each en=1 edge:
  - dcnt < DWELL-1: dcnt<=dcnt+1; ptr holds; wrap<=0.
  - dcnt == DWELL-1: dcnt<=0.
    - If ptr < CHANNELS-1: ptr<=ptr+1; wrap<=0.
    - If ptr == CHANNELS-1: ptr<=0; wrap<=1.
- dout is sampled from the pre-advance ptr on that same edge.
- Mode change takes effect on the next edge. Switching from scan to manual mid-dwell discards the dwell state.
- CHANNELS=1: ptr is constantly 0; in scan mode wrap pulses every DWELL enabled cycles.
- DWELL=1: ptr advances on every enabled edge.

## Timing
- Latency: din/sel to dout/ch is 1 clk edge. No combinational path from any input to any output.
- dout_n is always exactly ~dout, including during reset.
- wrap is high for exactly one cycle: the cycle after the edge that moved ptr from CHANNELS-1 to 0. During that cycle, dout shows the final sample of channel CHANNELS-1.
- In scan, each channel appears on dout for DWELL consecutive enabled cycles. en=0 cycles stretch the dwell without losing position.
- clrn asserted mid-scan clears everything immediately, regardless of en.

## Structure
- Shared package/include holds:
  - mode encodings MODE_MANUAL=0 and MODE_SCAN=1,
  - the clog2 helper used to derive SELW.
- Sub-module scan_counter (ptr, dcnt, wrap; parameters CHANNELS, DWELL; inputs clk, clrn, en, run) is natural. The top level holds the channel-select mux and the output registers.

## Test plan
All scenarios use WIDTH=4, CHANNELS=3, DWELL=2, with din = {ch2=4'hC, ch1=4'hA, ch0=4'h5} unless noted.
- Reset: clrn=0 mid-activity -> immediately dout=0, dout_n=4'hF, ch=0, valid=0, wrap=0. After release with en=0, all of these hold.
- Manual: mode=0, en=1, sel=1 -> after 1 edge dout=4'hA, dout_n=4'h5, ch=1, valid=1. Then sel=3 (out of range) -> dout stays 4'hA, ch stays 1, valid=0.
- Scan: mode=1, en=1 for 8 edges -> dout sequence 5,5,A,A,C,C,5,5 with ch 0,0,1,1,2,2,0,0. wrap=1 only in the cycle after the 6th edge.
- Enable gap: in scan, deassert en for 3 cycles after the first 4'hA sample -> valid=0 and dout holds 4'hA during the gap. On resume, one more 4'hA sample, then 4'hC.
- Mode switch: scan until ch=2, then mode=0 with sel=0 for 1 edge, then mode=1 -> scan restarts at ch=0 for 2 samples. No wrap pulse is produced by the switch.
- Degenerate: CHANNELS=1, DWELL=1, scan mode -> dout=din each edge, ch=0, wrap=1 on every enabled cycle after the first edge.
